// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// serial_tx_pkg : shared state encoding and default word width for the TX block
// Rev 1.0
// ============================================================================
package serial_tx_pkg;

   localparam int C_DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRANSFER = 2'd1,
      DONE     = 2'd2
   } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
// edge_detector : one-clk pulse on a 0-to-1 transition of a clk-synchronous input
// Rev 1.0
// ============================================================================
module edge_detector (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = sig;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign rise = sig & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// serial_transmitter : MSB-first parallel-to-serial shifter paced by clkTx ticks
// Rev 1.0
// ============================================================================
module serial_transmitter
   import serial_tx_pkg::*;
#(
   parameter int DATA_WIDTH = C_DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clkTx,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  dinValid,
   output logic                  clkEnable,
   output logic                  dout,
   output logic                  busy,
   output logic                  txDone
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  dout_q, dout_d;
   logic                  tick;

   edge_detector u_edge_detector (
      .clk   (clk),
      .reset (reset),
      .sig   (clkTx),
      .rise  (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         count_q <= '0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
      dout_d  = dout_q;
      case (state_q)
         IDLE: begin
            dout_d = 1'b0;
            // A coincident tick is deliberately ignored here: load only.
            if (dinValid) begin
               shift_d = din;
               count_d = CNT_W'(DATA_WIDTH);
               state_d = TRANSFER;
            end
         end
         TRANSFER: begin
            if (tick) begin
               if (count_q != '0) begin
                  dout_d  = shift_q[DATA_WIDTH-1];
                  shift_d = shift_q << 1;
                  count_d = count_q - 1'b1;
               end else begin
                  // The tick after the last bit closes its full clkTx period.
                  dout_d  = 1'b0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            dout_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            dout_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign dout      = dout_q;
   assign busy      = (state_q != IDLE);
   assign clkEnable = (state_q == TRANSFER);
   assign txDone    = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
// tb_serial_transmitter : scoreboard bench for a 32-bit and an 8-bit transmitter
// Rev 1.0
// ============================================================================
module tb_serial_transmitter;

   typedef struct packed {
      logic is_done;
      logic bit_v;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clkTx = 1'b0;
   logic        tx_hold = 1'b0;
   logic [1:0]  phase = 2'd0;
   logic [31:0] din0 = '0;
   logic        dv0 = 1'b0;
   logic [7:0]  din1 = '0;
   logic        dv1 = 1'b0;
   wire  [1:0]  ce, dout, busy, done;

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   done_cnt[2];
   int   bits_cnt[2];
   int   last_pop_cyc[2];
   logic last_bit[2];
   logic busy_chk[2];
   logic pre_tick = 1'b0;
   logic pre_rst = 1'b0;
   logic [1:0] pre_en = 2'b00;
   logic tx_hist = 1'b0;

   serial_transmitter #(.DATA_WIDTH(32)) u_dut0 (
      .clk(clk), .reset(reset), .clkTx(clkTx), .din(din0), .dinValid(dv0),
      .clkEnable(ce[0]), .dout(dout[0]), .busy(busy[0]), .txDone(done[0])
   );

   serial_transmitter #(.DATA_WIDTH(8)) u_dut1 (
      .clk(clk), .reset(reset), .clkTx(clkTx), .din(din1), .dinValid(dv1),
      .clkEnable(ce[1]), .dout(dout[1]), .busy(busy[1]), .txDone(done[1])
   );

   initial forever #5 clk = ~clk;

   // clkTx: 2 clk high / 2 clk low, or parked high while tx_hold is set
   initial forever begin
      @(negedge clk);
      if (tx_hold) begin
         clkTx = 1'b1;
         phase = 2'd3;
      end else begin
         phase = phase + 2'd1;
         clkTx = phase[1];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Pre-edge view of the inputs that decide whether the DUT sees a tick
   initial forever begin
      @(posedge clk);
      pre_tick = clkTx & ~tx_hist;
      pre_rst  = reset;
      pre_en   = ce;
      tx_hist  = reset ? clkTx : 1'b0;
      cyc++;
   end

   task automatic mon(input int k);
      exp_t e;
      int   qn;
      logic d, td, en, bz;
      d  = dout[k];
      td = done[k];
      en = ce[k];
      bz = busy[k];
      qn = (k == 0) ? sb0.size() : sb1.size();
      if (busy_chk[k]) begin
         check($sformatf("busy_falls_dut%0d", k), {31'd0, bz}, 32'd0);
         busy_chk[k] = 1'b0;
      end
      if (pre_rst && pre_en[k] && pre_tick) begin
         if (qn == 0) begin
            n_checks++;
            $display("FAIL unexpected_event_dut%0d: dout=%0b txDone=%0b with empty scoreboard", k, d, td);
         end else begin
            e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            if (e.is_done) begin
               check($sformatf("txDone_dut%0d", k), {31'd0, td}, 32'd1);
               check($sformatf("dout_in_done_dut%0d", k), {31'd0, d}, 32'd0);
               check($sformatf("done_gap_dut%0d", k), cyc - last_pop_cyc[k], 32'd4);
               busy_chk[k] = 1'b1;
               done_cnt[k]++;
            end else begin
               check($sformatf("bit%0d_dut%0d", bits_cnt[k], k), {31'd0, d}, {31'd0, e.bit_v});
               check($sformatf("txDone_low_dut%0d", k), {31'd0, td}, 32'd0);
               last_bit[k] = d;
               bits_cnt[k]++;
            end
            last_pop_cyc[k] = cyc;
         end
      end else begin
         check($sformatf("no_txDone_dut%0d", k), {31'd0, td}, 32'd0);
         if (en) begin
            check($sformatf("dout_hold_dut%0d", k), {31'd0, d}, {31'd0, last_bit[k]});
         end else begin
            last_bit[k] = 1'b0;
            check($sformatf("dout_idle_dut%0d", k), {31'd0, d}, 32'd0);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         done_cnt[k] = 0; bits_cnt[k] = 0; last_pop_cyc[k] = 0;
         last_bit[k] = 1'b0; busy_chk[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         mon(0);
         mon(1);
      end
   end

   task automatic push_word0(input logic [31:0] w);
      exp_t e;
      for (int i = 31; i >= 0; i--) begin
         e.is_done = 1'b0; e.bit_v = w[i]; sb0.push_back(e);
      end
      e.is_done = 1'b1; e.bit_v = 1'b0; sb0.push_back(e);
   endtask

   task automatic push_frame1_81();
      exp_t e;
      logic [7:0] bits;
      bits = 8'b1000_0001;
      for (int i = 7; i >= 0; i--) begin
         e.is_done = 1'b0; e.bit_v = bits[i]; sb1.push_back(e);
      end
      e.is_done = 1'b1; e.bit_v = 1'b0; sb1.push_back(e);
   endtask

   task automatic wait_done(input int k, input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt[k] < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt[k] < target) begin
         n_checks++;
         $display("FAIL timeout_dut%0d: done count %0d required %0d", k, done_cnt[k], target);
      end
   endtask

   task automatic check_outputs_zero(input int k, input string tag);
      check($sformatf("%s_dout_dut%0d", tag, k), {31'd0, dout[k]}, 32'd0);
      check($sformatf("%s_busy_dut%0d", tag, k), {31'd0, busy[k]}, 32'd0);
      check($sformatf("%s_txDone_dut%0d", tag, k), {31'd0, done[k]}, 32'd0);
      check($sformatf("%s_clkEnable_dut%0d", tag, k), {31'd0, ce[k]}, 32'd0);
   endtask

   initial begin
      int b0;
      // Reset held for two edges, then released
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      check_outputs_zero(0, "reset");
      check_outputs_zero(1, "reset");
      repeat (3) @(negedge clk);

      // Word A5000001, with a conflicting load request held mid-flight
      push_word0(32'hA500_0001);
      din0 = 32'hA500_0001; dv0 = 1'b1;
      @(negedge clk);
      dv0 = 1'b0;
      check("busy_after_load", {31'd0, busy[0]}, 32'd1);
      check("clkEnable_after_load", {31'd0, ce[0]}, 32'd1);
      @(negedge clk);
      din0 = 32'hFFFF_FFFF; dv0 = 1'b1;
      repeat (30) @(negedge clk);
      dv0 = 1'b0;
      wait_done(0, 1, 400);
      repeat (6) begin
         @(negedge clk);
         check("no_reload_busy", {31'd0, busy[0]}, 32'd0);
      end

      // Reset mid-word after 10 bits, then reload from the MSB
      push_word0(32'hA500_0001);
      b0 = bits_cnt[0];
      din0 = 32'hA500_0001; dv0 = 1'b1;
      @(negedge clk);
      dv0 = 1'b0;
      for (int n = 0; n < 200 && bits_cnt[0] < b0 + 10; n++) @(posedge clk);
      check("bits_before_reset", ((bits_cnt[0] - b0) >= 10) ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      sb0.delete();
      check_outputs_zero(0, "midreset");
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("no_done_after_abort", done_cnt[0], 32'd1);
      push_word0(32'hA500_0001);
      din0 = 32'hA500_0001; dv0 = 1'b1;
      @(negedge clk);
      dv0 = 1'b0;
      wait_done(0, 2, 400);

      // clkTx already high at load: first bit waits for a fresh rising edge
      @(negedge clk);
      tx_hold = 1'b1;
      repeat (4) @(negedge clk);
      push_word0(32'h8000_0001);
      b0 = bits_cnt[0];
      din0 = 32'h8000_0001; dv0 = 1'b1;
      @(negedge clk);
      dv0 = 1'b0;
      repeat (10) @(negedge clk);
      check("no_bit_while_high", bits_cnt[0] - b0, 32'd0);
      check("dout_while_high", {31'd0, dout[0]}, 32'd0);
      tx_hold = 1'b0;
      wait_done(0, 3, 400);

      // 8-bit instance: two back-to-back 8'h81 frames
      push_frame1_81();
      push_frame1_81();
      @(negedge clk);
      din1 = 8'h81; dv1 = 1'b1;
      @(negedge clk);
      dv1 = 1'b0;
      wait_done(1, 1, 200);
      @(negedge clk);
      dv1 = 1'b1;
      @(negedge clk);
      dv1 = 1'b0;
      check("second_frame_loaded", {31'd0, busy[1]}, 32'd1);
      wait_done(1, 2, 200);
      repeat (4) @(negedge clk);
      check("sb0_drained", sb0.size(), 32'd0);
      check("sb1_drained", sb1.size(), 32'd0);
      check("frames_dut1", done_cnt[1], 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of the parallel word shifted out.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Port: clkTx  input  1  divided clock from the frequency divider, synchronous to clk; its rising edges pace the bits.
REQ-005 Port: din  input  DATA_WIDTH  parallel word to transmit.
REQ-006 Port: dinValid  input  1  load request for din.
REQ-007 Port: clkEnable  output  1  enable for the frequency divider; high while transmitting.
REQ-008 Port: dout  output  1  serial data, MSB first.
REQ-009 Port: busy  output  1  high from load until the end of DONE.
REQ-010 Port: txDone  output  1  one-clk pulse at the end of a word.

Function
REQ-011 The block SHALL implement the states IDLE, TRANSFER and DONE.
REQ-012 The block SHALL detect a tick as a clk cycle where clkTx is 1 and its registered previous value is 0.
REQ-013 In IDLE with dinValid=1, the block SHALL capture din into the shift register, load the bit counter with DATA_WIDTH, and enter TRANSFER on the next edge.
REQ-014 In TRANSFER, clkEnable and busy SHALL be 1.
REQ-015 On each tick in TRANSFER with counter>0, the block SHALL drive dout with the shift register MSB, shift left by one (zero fill), and decrement the counter, all on the same edge.
REQ-016 On a tick in TRANSFER with counter=0, the block SHALL enter DONE, so the last bit is held for one full clkTx period.
REQ-017 DONE SHALL last exactly one clk cycle with txDone=1, busy=1, clkEnable=0 and dout=0, then return to IDLE.
REQ-018 In IDLE, dout, busy, txDone and clkEnable SHALL be 0.
REQ-019 The block SHALL ignore dinValid outside IDLE; din SHALL NOT affect a word in flight.
REQ-020 A tick and dinValid in the same IDLE cycle SHALL load only; no bit is emitted that cycle.
REQ-021 If clkTx is already high at load, the first tick SHALL require a new 0-to-1 transition.
REQ-022 The counter SHALL be clog2(DATA_WIDTH+1) bits wide and never wrap below 0.

Reset
REQ-023 With reset=0 at a rising clk, the state SHALL become IDLE, the shift register and counter 0, the clkTx history 0, and all outputs 0.
REQ-024 Reset during TRANSFER or DONE SHALL abort the word with no txDone pulse.
REQ-025 Reset SHALL take priority over dinValid and tick in the same cycle.

Structure
REQ-026 A shared package serial_tx_pkg SHALL hold the state typedef (IDLE, TRANSFER, DONE) and the default DATA_WIDTH constant.
REQ-027 Rising-edge detection of clkTx SHALL be a sub-module named edge_detector (ports clk, reset, sig, rise).

Verification
REQ-028 Reset held 2 cycles, then released -> all outputs 0, state IDLE.
REQ-029 din=32'hA5000001, dinValid pulsed 1 cycle, clkTx period 4 clk (2 high / 2 low) -> dout shows bits 1,0,1,0,0,1,0,1,0...0,1 on successive ticks, each held 4 clk; txDone pulses once, 4 clk after the last bit starts; busy falls with it.
REQ-030 dinValid=1 with din=32'hFFFFFFFF during the REQ-029 transfer -> no change to the serial stream; the second word is only accepted after return to IDLE.
REQ-031 reset=0 asserted mid-word after 10 bits -> outputs 0 the next cycle, no txDone, a subsequent load restarts from the MSB.
REQ-032 clkTx held high at load, then toggled -> first bit appears only after the next 0-to-1 transition.
REQ-033 DATA_WIDTH=8, din=8'h81, back-to-back loads in consecutive IDLE windows -> two complete frames of 1,0,0,0,0,0,0,1, each followed by a single txDone pulse.
